data_sync: RTL and testbench



---
 rtl/data_sync.sv | 101 ++++++++++
 tb/tb_data_sync.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_sync.sv
// Destination-domain bus synchronizer: enable level through a flop chain, rising-edge capture of
// the bus, valid/ack handshake and sticky overrun. Optional parity check: DATA_SYNC_PARITY_EN.
module data_sync #(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned BUS_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 UNSYNC_PAR,
  input  logic                 BUS_ENABLE,
  input  logic                 RD_ACK,
  input  logic                 OVR_CLR,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic                 SYNC_VALID,
  output logic                 OVERRUN,
  output logic                 PAR_ERR
);

  if (NUM_STAGES < 2 || NUM_STAGES > 4) begin : g_bad_stages
    $error("data_sync: NUM_STAGES must be in 2..4");
  end

  logic [NUM_STAGES-1:0] sync_q;
  logic                  en_dly_q;
  logic                  pulse_det;
  logic [BUS_WIDTH-1:0]  bus_q;
  logic                  pulse_q;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q   <= '0;
      en_dly_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[NUM_STAGES-2:0], BUS_ENABLE};
      en_dly_q <= sync_q[NUM_STAGES-1];
    end
  end

  assign pulse_det = sync_q[NUM_STAGES-1] & ~en_dly_q;

  always_comb begin
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (pulse_det) begin
      valid_d = 1'b1;
    end else if (RD_ACK) begin
      valid_d = 1'b0;
    end
    if (OVR_CLR) begin
      ovr_d = 1'b0;
    end
    // An ack in the capture cycle consumes the old word, so it is not an overrun; set beats clear.
    if (pulse_det && valid_q && !RD_ACK) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus_q   <= '0;
      pulse_q <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pulse_q <= pulse_det;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      if (pulse_det) begin
        bus_q <= UNSYNC_BUS;
      end
    end
  end

  assign SYNC_BUS     = bus_q;
  assign ENABLE_PULSE = pulse_q;
  assign SYNC_VALID   = valid_q;
  assign OVERRUN      = ovr_q;

`ifdef DATA_SYNC_PARITY_EN
  logic par_err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_err_q <= 1'b0;
    end else if (pulse_det) begin
      par_err_q <= (^UNSYNC_BUS) ^ UNSYNC_PAR;
    end
  end

  assign PAR_ERR = par_err_q;
`else
  logic unused_par;
  assign unused_par = UNSYNC_PAR;
  assign PAR_ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_data_sync.sv
// Directed bench for data_sync: a scoreboard queue holds words as they are driven and each
// capture pops and compares; immediate assertions at every comparison point.
module tb_data_sync;

  localparam int unsigned NUM_STAGES = 2;
  localparam int unsigned BUS_WIDTH  = 8;

  typedef struct packed {
    logic [BUS_WIDTH-1:0] data;
    logic                 perr;
  } exp_t;

  logic                 CLK_tb = 1'b0;
  logic                 RST_tb = 1'b1;
  logic [BUS_WIDTH-1:0] UNSYNC_BUS_tb = '0;
  logic                 UNSYNC_PAR_tb = 1'b0;
  logic                 BUS_ENABLE_tb = 1'b0;
  logic                 RD_ACK_tb = 1'b0;
  logic                 OVR_CLR_tb = 1'b0;
  logic [BUS_WIDTH-1:0] SYNC_BUS_tb;
  logic                 ENABLE_PULSE_tb;
  logic                 SYNC_VALID_tb;
  logic                 OVERRUN_tb;
  logic                 PAR_ERR_tb;

  int   vectors     = 0;
  int   miscompares = 0;
  int   pulse_cnt   = 0;
  int   snap;
  exp_t sb_q[$];

  data_sync #(
    .NUM_STAGES(NUM_STAGES),
    .BUS_WIDTH (BUS_WIDTH)
  ) dut (
    .CLK         (CLK_tb),
    .RST         (RST_tb),
    .UNSYNC_BUS  (UNSYNC_BUS_tb),
    .UNSYNC_PAR  (UNSYNC_PAR_tb),
    .BUS_ENABLE  (BUS_ENABLE_tb),
    .RD_ACK      (RD_ACK_tb),
    .OVR_CLR     (OVR_CLR_tb),
    .SYNC_BUS    (SYNC_BUS_tb),
    .ENABLE_PULSE(ENABLE_PULSE_tb),
    .SYNC_VALID  (SYNC_VALID_tb),
    .OVERRUN     (OVERRUN_tb),
    .PAR_ERR     (PAR_ERR_tb)
  );

  always #5 CLK_tb = ~CLK_tb;

  always @(negedge CLK_tb) begin
    if (ENABLE_PULSE_tb === 1'b1) pulse_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_perr(input logic [BUS_WIDTH-1:0] d, input logic p);
`ifdef DATA_SYNC_PARITY_EN
    return (^d) ^ p;
`else
    return 1'b0 & (^d) & p;
`endif
  endfunction

  task automatic check_zero(input string tag);
    check({tag, ".bus"},   32'(SYNC_BUS_tb), 32'h0);
    check({tag, ".pulse"}, 32'(ENABLE_PULSE_tb), 32'h0);
    check({tag, ".valid"}, 32'(SYNC_VALID_tb), 32'h0);
    check({tag, ".ovr"},   32'(OVERRUN_tb), 32'h0);
    check({tag, ".perr"},  32'(PAR_ERR_tb), 32'h0);
  endtask

  // Pop the scoreboard and compare against the captured word; called on the pulse cycle.
  task automatic check_capture(input string tag);
    exp_t e;
    check({tag, ".pulse"}, 32'(ENABLE_PULSE_tb), 32'h1);
    check({tag, ".sbq"}, 32'(sb_q.size() > 0), 32'h1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, ".bus"},  32'(SYNC_BUS_tb), 32'(e.data));
      check({tag, ".perr"}, 32'(PAR_ERR_tb), 32'(e.perr));
    end
    check({tag, ".valid"}, 32'(SYNC_VALID_tb), 32'h1);
  endtask

  // Raise the enable, optionally pulse ack/clear in the capture cycle, check exact latency.
  task automatic capture(input string tag, input logic [BUS_WIDTH-1:0] d, input logic p,
                         input logic ack, input logic clr);
    @(negedge CLK_tb);
    UNSYNC_BUS_tb = d;
    UNSYNC_PAR_tb = p;
    BUS_ENABLE_tb = 1'b1;
    sb_q.push_back('{data: d, perr: exp_perr(d, p)});
    repeat (NUM_STAGES) @(negedge CLK_tb);
    check({tag, ".early"}, 32'(ENABLE_PULSE_tb), 32'h0);
    RD_ACK_tb  = ack;
    OVR_CLR_tb = clr;
    @(negedge CLK_tb);
    RD_ACK_tb  = 1'b0;
    OVR_CLR_tb = 1'b0;
    check_capture(tag);
  endtask

  task automatic drop(input string tag);
    @(negedge CLK_tb);
    BUS_ENABLE_tb = 1'b0;
    check({tag, ".onecyc"}, 32'(ENABLE_PULSE_tb), 32'h0);
  endtask

  task automatic ack(input string tag);
    @(negedge CLK_tb);
    RD_ACK_tb = 1'b1;
    @(negedge CLK_tb);
    RD_ACK_tb = 1'b0;
    check({tag, ".valid"}, 32'(SYNC_VALID_tb), 32'h0);
  endtask

  task automatic ovr_clear(input string tag);
    @(negedge CLK_tb);
    OVR_CLR_tb = 1'b1;
    @(negedge CLK_tb);
    OVR_CLR_tb = 1'b0;
    check({tag, ".ovr"}, 32'(OVERRUN_tb), 32'h0);
  endtask

  initial begin
    #3;
    check_zero("por");
    @(negedge CLK_tb);
    RST_tb = 1'b0;
    repeat (4) @(negedge CLK_tb);
    check("idle.pulses", 32'(pulse_cnt), 32'h0);

    capture("basic", 8'hA5, 1'b0, 1'b0, 1'b0);
    drop("basic");
    check("basic.hold", 32'(SYNC_VALID_tb), 32'h1);
    ack("basic");

    snap = pulse_cnt;
    capture("held", 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (18) @(negedge CLK_tb);
    check("held.count", 32'(pulse_cnt - snap), 32'h1);
    check("held.bus", 32'(SYNC_BUS_tb), 32'h3C);
    drop("held");
    ack("held");

    capture("ovr1", 8'h11, 1'b0, 1'b0, 1'b0);
    drop("ovr1");
    check("ovr1.ovr", 32'(OVERRUN_tb), 32'h0);
    capture("ovr2", 8'h22, 1'b0, 1'b0, 1'b0);
    check("ovr2.ovr", 32'(OVERRUN_tb), 32'h1);
    drop("ovr2");
    check("ovr2.sticky", 32'(OVERRUN_tb), 32'h1);
    ovr_clear("ovr2");

    capture("ackcoin", 8'h44, 1'b0, 1'b1, 1'b0);
    check("ackcoin.ovr", 32'(OVERRUN_tb), 32'h0);
    drop("ackcoin");

    capture("collide", 8'h55, 1'b0, 1'b0, 1'b1);
    check("collide.ovr", 32'(OVERRUN_tb), 32'h1);
    drop("collide");
    ovr_clear("collide");
    ack("collide");

    capture("par_ok", 8'h07, 1'b1, 1'b0, 1'b0);
    drop("par_ok");
    ack("par_ok");
    capture("par_bad", 8'h07, 1'b0, 1'b0, 1'b0);
    drop("par_bad");
    ack("par_bad");
    check("par_bad.held", 32'(PAR_ERR_tb), 32'(exp_perr(8'h07, 1'b0)));

    ack("ignored");
    check("ignored.ovr", 32'(OVERRUN_tb), 32'h0);

    // Asynchronous reset mid-capture with valid data held and the enable toggling.
    capture("prerst", 8'h66, 1'b1, 1'b0, 1'b0);
    @(negedge CLK_tb);
    BUS_ENABLE_tb = 1'b0;
    @(negedge CLK_tb);
    BUS_ENABLE_tb = 1'b1;
    #2;
    RST_tb = 1'b1;
    #1;
    check_zero("async_rst");
    repeat (3) @(negedge CLK_tb);
    BUS_ENABLE_tb = 1'b0;
    RST_tb = 1'b0;
    snap = pulse_cnt;
    repeat (6) @(negedge CLK_tb);
    check("rst_low.pulses", 32'(pulse_cnt - snap), 32'h0);
    check("rst_low.valid", 32'(SYNC_VALID_tb), 32'h0);

    // Enable already high at reset release counts as one new word.
    RST_tb = 1'b1;
    UNSYNC_BUS_tb = 8'h77;
    UNSYNC_PAR_tb = 1'b1;
    BUS_ENABLE_tb = 1'b1;
    @(negedge CLK_tb);
    RST_tb = 1'b0;
    sb_q.push_back('{data: 8'h77, perr: exp_perr(8'h77, 1'b1)});
    repeat (NUM_STAGES) @(negedge CLK_tb);
    check("rst_high.early", 32'(ENABLE_PULSE_tb), 32'h0);
    @(negedge CLK_tb);
    check_capture("rst_high");
    drop("rst_high");

    check("sb.empty", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
